// File: rtl/output_spike_monitor.sv
// Counts output-layer spikes per neuron over windows of SNN time steps and
// queues one {count0, count1, window index} result per window in a small FIFO.
module output_spike_monitor #(
    parameter int CNT_W      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             system_clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             delay_clk,
    input  logic [1:0]       output_spikes,
    input  logic [7:0]       window_len,
    input  logic             count_ready,
    output logic             count_valid,
    output logic [CNT_W-1:0] spike_count0,
    output logic [CNT_W-1:0] spike_count1,
    output logic [7:0]       window_index,
    output logic             overflow
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] c0;
        logic [CNT_W-1:0] c1;
        logic [7:0]       idx;
    } entry_t;

    state_t           state_q, state_d;
    logic             delayClk_q;
    logic [7:0]       step_q, step_d;
    logic [7:0]       len_q, len_d;
    logic             fresh_q, fresh_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [7:0]       winIdx_q, winIdx_d;
    logic [AW-1:0]    rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
    logic [AW:0]      occ_q, occ_d;
    logic             overflow_q, overflow_d;
    entry_t           mem [FIFO_DEPTH];

    logic             tick, countTick, close, full, push, pop;
    logic [7:0]       effLen, stepInc;
    logic [CNT_W-1:0] sat0, sat1;
    entry_t           newEntry, head;

    // fresh_q marks a window start, where window_len is taken live and latched;
    // the 8-bit step wrap makes window_len=0 close on the 256th step.
    always_comb begin
        state_d    = enable ? RUN : IDLE;
        tick       = delay_clk & ~delayClk_q;
        countTick  = tick && (state_q == RUN);
        effLen     = fresh_q ? window_len : len_q;
        stepInc    = step_q + 8'd1;
        sat0       = (cnt0_q == '1) ? cnt0_q : cnt0_q + CNT_W'(output_spikes[0]);
        sat1       = (cnt1_q == '1) ? cnt1_q : cnt1_q + CNT_W'(output_spikes[1]);
        close      = countTick && (stepInc == effLen);
        full       = (occ_q == (AW+1)'(FIFO_DEPTH));
        pop        = count_valid && count_ready;
        push       = close && (!full || pop);
        newEntry   = '{c0: sat0, c1: sat1, idx: winIdx_q};

        step_d     = step_q;
        len_d      = len_q;
        fresh_d    = fresh_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        winIdx_d   = winIdx_q;
        overflow_d = overflow_q | (close && full && !pop);
        rdPtr_d    = pop  ? rdPtr_q + AW'(1) : rdPtr_q;
        wrPtr_d    = push ? wrPtr_q + AW'(1) : wrPtr_q;

        if (countTick) begin
            fresh_d = 1'b0;
            len_d   = effLen;
            step_d  = stepInc;
            cnt0_d  = sat0;
            cnt1_d  = sat1;
        end
        if (close) begin
            fresh_d  = 1'b1;
            step_d   = '0;
            cnt0_d   = '0;
            cnt1_d   = '0;
            winIdx_d = winIdx_q + 8'd1;
        end

        occ_d = occ_q;
        if (push && !pop)
            occ_d = occ_q + (AW+1)'(1);
        else if (pop && !push)
            occ_d = occ_q - (AW+1)'(1);
    end

    always_ff @(posedge system_clock) begin
        if (reset) begin
            state_q    <= IDLE;
            delayClk_q <= 1'b0;
            step_q     <= '0;
            len_q      <= '0;
            fresh_q    <= 1'b1;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            winIdx_q   <= '0;
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            delayClk_q <= delay_clk;
            step_q     <= step_d;
            len_q      <= len_d;
            fresh_q    <= fresh_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            winIdx_q   <= winIdx_d;
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: the head is masked whenever occupancy is zero.
    always_ff @(posedge system_clock) begin
        if (!reset && push)
            mem[wrPtr_q] <= newEntry;
    end

    always_comb begin
        head         = mem[rdPtr_q];
        count_valid  = (occ_q != '0);
        spike_count0 = count_valid ? head.c0  : '0;
        spike_count1 = count_valid ? head.c1  : '0;
        window_index = count_valid ? head.idx : '0;
        overflow     = overflow_q;
    end

endmodule

// File: tb/tb_output_spike_monitor.sv
// Scoreboard bench: directed stimulus queues expected window results, a
// negedge monitor pops and compares them whenever the DUT hands one over.
module tb_output_spike_monitor;

    typedef struct packed {
        logic [7:0] c0;
        logic [7:0] c1;
        logic [7:0] idx;
    } exp_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       delay_clk = 1'b0;
    logic [1:0] output_spikes = 2'b00;
    logic [7:0] window_len = 8'd4;
    logic       count_ready = 1'b0;
    logic       count_valid;
    logic [7:0] spike_count0, spike_count1, window_index;
    logic       overflow;

    exp_t expQ[$];
    int   assertCount = 0;
    int   failCount   = 0;

    output_spike_monitor #(.CNT_W(8), .FIFO_DEPTH(4)) dut (
        .system_clock (clock),
        .reset        (reset),
        .enable       (enable),
        .delay_clk    (delay_clk),
        .output_spikes(output_spikes),
        .window_len   (window_len),
        .count_ready  (count_ready),
        .count_valid  (count_valid),
        .spike_count0 (spike_count0),
        .spike_count1 (spike_count1),
        .window_index (window_index),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    function automatic exp_t mk(input int c0, input int c1, input int idx);
        exp_t e;
        e.c0  = 8'(c0);
        e.c1  = 8'(c1);
        e.idx = 8'(idx);
        return e;
    endfunction

    // Inputs change 1 time unit after posedge; the monitor samples at negedge.
    always @(negedge clock) begin
        if (!reset && count_valid && count_ready) begin
            exp_t got, want;
            got = {spike_count0, spike_count1, window_index};
            assertCount++;
            if (expQ.size() == 0) begin
                failCount++;
                $display("[TB] FAIL unexpected_pop: got c0=%0d c1=%0d idx=%0d, expected no entry",
                         got.c0, got.c1, got.idx);
            end else begin
                want = expQ.pop_front();
                if (got !== want) begin
                    failCount++;
                    $display("[TB] FAIL pop_entry: got c0=%0d c1=%0d idx=%0d, expected c0=%0d c1=%0d idx=%0d",
                             got.c0, got.c1, got.idx, want.c0, want.c1, want.idx);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One SNN time step: delay_clk high for one cycle, then low for one cycle.
    task automatic applyStimulus(input logic [1:0] spikes);
        @(posedge clock); #1;
        delay_clk     = 1'b1;
        output_spikes = spikes;
        @(posedge clock); #1;
        delay_clk = 1'b0;
    endtask

    task automatic doReset();
        @(posedge clock); #1;
        reset     = 1'b1;
        delay_clk = 1'b0;
        expQ.delete();
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 60; i++) begin
            if (expQ.size() == 0 && !count_valid) break;
            @(posedge clock); #1;
        end
        checkOutput(name, {30'd0, expQ.size() == 0, count_valid}, 32'd2);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Basic window of 4 steps, neuron 0 firing every step.
        doReset();
        checkOutput("reset_valid", count_valid, 0);
        checkOutput("reset_c0", spike_count0, 0);
        checkOutput("reset_c1", spike_count1, 0);
        checkOutput("reset_idx", window_index, 0);
        checkOutput("reset_ovf", overflow, 0);
        window_len = 8'd4; enable = 1'b1; count_ready = 1'b0;
        for (int i = 0; i < 3; i++) applyStimulus(2'b01);
        checkOutput("w4_valid_early", count_valid, 0);
        expQ.push_back(mk(4, 0, 0));
        applyStimulus(2'b01);
        checkOutput("w4_valid_latency", count_valid, 1);
        checkOutput("w4_head_c0", spike_count0, 4);
        count_ready = 1'b1;
        waitDrain("w4_drain");
        checkOutput("empty_c0_zero", spike_count0, 0);
        checkOutput("empty_idx_zero", window_index, 0);

        // 256-step window with both neurons saturating.
        doReset();
        window_len = 8'd0; enable = 1'b1; count_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (i == 255) expQ.push_back(mk(255, 255, 0));
            applyStimulus(2'b11);
        end
        waitDrain("sat_drain");
        checkOutput("sat_ovf", overflow, 0);

        // Single-step windows with the consumer stalled until overflow.
        doReset();
        window_len = 8'd1; enable = 1'b1; count_ready = 1'b0;
        expQ.push_back(mk(1, 0, 0)); applyStimulus(2'b01);
        expQ.push_back(mk(0, 1, 1)); applyStimulus(2'b10);
        expQ.push_back(mk(1, 1, 2)); applyStimulus(2'b11);
        expQ.push_back(mk(0, 0, 3)); applyStimulus(2'b00);
        checkOutput("full_no_ovf", overflow, 0);
        applyStimulus(2'b11);
        checkOutput("drop_ovf", overflow, 1);
        checkOutput("stall_head_c0", spike_count0, 1);
        checkOutput("stall_head_idx", window_index, 0);
        count_ready = 1'b1;
        waitDrain("ovf_drain");
        checkOutput("ovf_sticky", overflow, 1);

        // Enable drop mid-window: disabled steps must not count.
        doReset();
        window_len = 8'd4; enable = 1'b1; count_ready = 1'b1;
        applyStimulus(2'b01);
        applyStimulus(2'b01);
        enable = 1'b0;
        @(posedge clock); #1;
        for (int i = 0; i < 3; i++) applyStimulus(2'b11);
        checkOutput("idle_no_valid", count_valid, 0);
        enable = 1'b1;
        @(posedge clock); #1;
        applyStimulus(2'b10);
        expQ.push_back(mk(2, 2, 0));
        applyStimulus(2'b10);
        waitDrain("resume_drain");

        // Full FIFO with a pop in the same cycle as the closing push.
        doReset();
        window_len = 8'd1; enable = 1'b1; count_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expQ.push_back(mk(1, 0, i));
            applyStimulus(2'b01);
        end
        @(posedge clock); #1;
        delay_clk = 1'b1; output_spikes = 2'b11; count_ready = 1'b1;
        expQ.push_back(mk(1, 1, 4));
        @(posedge clock); #1;
        delay_clk = 1'b0; count_ready = 1'b0;
        checkOutput("pushpop_ovf", overflow, 0);
        checkOutput("pushpop_head_idx", window_index, 1);
        count_ready = 1'b1;
        waitDrain("pushpop_drain");

        // Reset with entries queued and a partial window in progress.
        doReset();
        window_len = 8'd1; enable = 1'b1; count_ready = 1'b0;
        applyStimulus(2'b01);
        applyStimulus(2'b01);
        window_len = 8'd4;
        applyStimulus(2'b11);
        checkOutput("pre_reset_valid", count_valid, 1);
        doReset();
        checkOutput("midreset_valid", count_valid, 0);
        checkOutput("midreset_ovf", overflow, 0);
        checkOutput("midreset_c1", spike_count1, 0);
        window_len = 8'd2; count_ready = 1'b1;
        applyStimulus(2'b10);
        window_len = 8'd3;
        expQ.push_back(mk(0, 2, 0));
        applyStimulus(2'b10);
        waitDrain("post_reset_drain");
        window_len = 8'd4;

        repeat (4) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
